nonce_report_queue: RTL
=======================

NONCE_REPORT_QUEUE -- requirements
Module: nonce_report_queue

Interface
REQ-001 Parameter DEPTH, default 8, number of FIFO entries; power of two, 2..64.
REQ-002 Parameter BUSY_TIMEOUT, default 4, number of cycles to wait for tx_busy to rise after tx_send.
REQ-003 Port clk, input, 1, single clock for all logic; comm clock domain.
REQ-004 Port rst, input, 1, reset; asynchronous and active-high.
REQ-005 Port got_ticket, input, 1, level flag from the hash core; may be asynchronous to clk; high while nonce is valid.
REQ-006 Port golden_nonce, input, 32, found nonce; stable while got_ticket is high.
REQ-007 Port tx_busy, input, 1, serial transmitter busy flag.
REQ-008 Port tx_send, output, 1, one-cycle request to the serial core to transmit tx_word.
REQ-009 Port tx_word, output, 32, nonce to transmit; held stable from tx_send until tx_busy falls.
REQ-010 Port new_nonce, output, 1, one-cycle pulse for each nonce accepted into the FIFO (drives the LED fader).
REQ-011 Port pending, output, clog2(DEPTH)+1, current FIFO occupancy.
REQ-012 Port overflow_count, output, 8, count of dropped nonces; saturates at 255.

Function
REQ-013 got_ticket SHALL pass through a 2-flop synchronizer, followed by a third delay flop for rising-edge detection.
REQ-014 A detected rising edge SHALL push golden_nonce, sampled in the detect cycle, into the FIFO on the next clk edge; this is the 3rd rising edge after got_ticket is first sampled high.
REQ-015 A level held high SHALL produce exactly one push; a new push requires got_ticket to go low for at least 2 clk cycles, then high again.
REQ-016 new_nonce SHALL pulse high for one cycle in the cycle after each accepted push.
REQ-017 The FIFO SHALL be a circular buffer with wrapping read and write pointers; pending SHALL equal writes minus reads.
REQ-018 Push when full with no pop in the same cycle: the nonce SHALL be dropped and overflow_count incremented, saturating at 255; FIFO contents SHALL be unchanged.
REQ-019 Simultaneous push and pop: both SHALL succeed, including when full; pending SHALL be unchanged.
REQ-020 The sender FSM SHALL have states IDLE, ARM, WAIT_BUSY and WAIT_DONE.
REQ-021 IDLE -> ARM when pending != 0 and tx_busy == 0; on that edge, load tx_word with the head entry and pop it.
REQ-022 ARM: tx_send = 1 for exactly this one cycle; go to WAIT_BUSY.
REQ-023 WAIT_BUSY: go to WAIT_DONE when tx_busy == 1; after BUSY_TIMEOUT cycles without tx_busy, go to IDLE and discard the word.
REQ-024 WAIT_DONE: go to IDLE when tx_busy == 0.
REQ-025 tx_send SHALL be low in all states except ARM.
REQ-026 Nonces SHALL be transmitted in arrival order; no reordering and no duplication.
REQ-027 Pushes SHALL continue to be accepted in every FSM state.

Reset
REQ-028 While rst is high, the following SHALL hold, independent of clk: FIFO empty, pointers 0, pending 0, overflow_count 0, FSM IDLE, tx_send 0, tx_word 0, new_nonce 0, synchronizer flops 0.
REQ-029 Reset asserted mid-transfer SHALL discard all queued and in-flight nonces.
REQ-030 After deassertion, a got_ticket already high SHALL be treated as a rising edge and pushed once.

Verification
REQ-031 Single nonce: got_ticket high with 0xDEADBEEF, tx_busy idle -> new_nonce pulses once; tx_send pulses once with tx_word = 0xDEADBEEF, at edge 5 after first sample.
REQ-032 Burst: 3 nonces 0x1, 0x2, 0x3, with tx_busy modelled as 10 cycles per word -> three tx_send pulses, words in order 0x1, 0x2, 0x3; pending returns to 0.
REQ-033 Overflow: tx_busy stuck high, 10 nonces, DEPTH = 8 -> pending = 8, overflow_count = 2; after tx_busy is released, the first 8 nonces are sent in order.
REQ-034 Timeout: tx_busy never rises -> tx_send pulses, FSM returns to IDLE after 4 cycles, and the next entry is sent.
REQ-035 Full plus simultaneous push/pop: FIFO full and FSM popping in the same cycle as a new push -> no drop; overflow_count unchanged; pending stays 8.
REQ-036 Reset mid-operation: rst pulsed while in WAIT_DONE with 5 entries pending -> all outputs return to their reset values; no tx_send until a new nonce arrives.

Source files
------------

// File: rtl/nonce_report_queue.sv
// Nonce report queue: synchronizes the hash core's got_ticket flag, buffers found nonces
// in a circular FIFO and hands them, oldest first, to the serial transmitter.
module nonce_report_queue #(
  parameter int DEPTH        = 8,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   got_ticket,
  input  logic [31:0]            golden_nonce,
  input  logic                   tx_busy,
  output logic                   tx_send,
  output logic [31:0]            tx_word,
  output logic                   new_nonce,
  output logic [$clog2(DEPTH):0] pending,
  output logic [7:0]             overflow_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ARM, WAIT_BUSY, WAIT_DONE} state_t;

  state_t        state, state_next;
  logic [2:0]    ticket_sync;
  logic          ticket_rise;
  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full, pop, push, drop;
  logic [TW-1:0] timer;

  // Two synchronizer stages, then a delay stage used only for rising-edge detection.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ticket_sync <= '0;
    else     ticket_sync <= {ticket_sync[1:0], got_ticket};
  end

  assign ticket_rise = ticket_sync[1] & ~ticket_sync[2];

  assign fifo_full = (count == (AW+1)'(DEPTH));
  assign pop       = (state == IDLE) && (count != '0) && !tx_busy;
  // A pop on the same edge frees the slot, so a full queue still accepts the push.
  assign push      = ticket_rise && (!fifo_full || pop);
  assign drop      = ticket_rise && fifo_full && !pop;

  // NOTE: storage has no reset; emptiness is defined by the pointers and count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= golden_nonce;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      overflow_count <= '0;
      new_nonce      <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: ;
      endcase
      if (drop && (overflow_count != 8'hFF)) overflow_count <= overflow_count + 8'd1;
      new_nonce <= push;
    end
  end

  assign pending = count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    // NOTE: default first so no path through the case leaves state_next unassigned (no latch).
    state_next = state;
    case (state)
      IDLE:      if (pop) state_next = ARM;
      ARM:       state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (tx_busy)                             state_next = WAIT_DONE;
        else if (timer == TW'(BUSY_TIMEOUT - 1)) state_next = IDLE;
      end
      WAIT_DONE: if (!tx_busy) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    tx_send = 1'b0;
    if (state == ARM) tx_send = 1'b1;
  end

  // tx_word only changes on a pop, so it stays put for the whole transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_word <= '0;
      timer   <= '0;
    end else begin
      if (pop) tx_word <= mem[rd_ptr];
      if (state == WAIT_BUSY) timer <= timer + TW'(1);
      else                    timer <= '0;
    end
  end

endmodule
